pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, number of consecutive cycles both IF/ID and ID/EX are flushed per taken branch (legal range 1..3).
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_rs, id_rt  in  5 each  source register indices of the instruction in decode.
REQ-006 id_uses_rt  in  1  decode instruction reads rt as a source.
REQ-007 ex_memRead  in  1  the instruction in ID/EX is a load.
REQ-008 ex_rt  in  5  load destination index held in ID/EX.
REQ-009 branch_taken  in  1  taken branch resolved; arrives registered from EX/MEM.
REQ-010 mem_busy  in  1  data-memory access not complete; the whole pipeline must hold.
REQ-011 pc_write  out  1  PC may load its next value.
REQ-012 if_id_write  out  1  IF/ID may capture.
REQ-013 if_id_flush  out  1  IF/ID captures a NOP.
REQ-014 id_ex_flush  out  1  ID/EX clears its control bits (bubble); same meaning as the existing flush of the ID/EX control fields.
REQ-015 pipe_hold  out  1  ID/EX and EX/MEM keep their contents.
REQ-016 stall_count, flush_count  out  CNT_W each  saturating event counters.

Function
REQ-017 ld_use SHALL equal ex_memRead & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))); it is combinational.
REQ-018 States SHALL be RUN, FLUSH, FREEZE; outputs are combinational from state and inputs (zero latency).
REQ-019 Priority per cycle SHALL be: mem_busy > FLUSH state > branch_taken > ld_use > normal.
REQ-020 mem_busy=1, any state: pc_write=0, if_id_write=0, pipe_hold=1, both flushes 0; next state FREEZE; the remaining flush count is preserved; stall_count +1.
REQ-021 FREEZE with mem_busy=0 SHALL behave exactly like RUN in that cycle, or like FLUSH if a flush count remains.
REQ-022 RUN + branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, pipe_hold=0; flush_count +1; if FLUSH_CYCLES>1, go to FLUSH with remaining count FLUSH_CYCLES-1, else stay in RUN.
REQ-023 FLUSH: pc_write=1, if_id_flush=1, id_ex_flush=1; decrement the remaining count; return to RUN when it reaches 0; branch_taken and ld_use are ignored.
REQ-024 RUN + ld_use (no branch): pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0; stall_count +1; the state stays RUN, so the next cycle re-evaluates ld_use.
REQ-025 Normal: pc_write=1, if_id_write=1, flushes 0, pipe_hold=0.
REQ-026 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 Unencoded state values SHALL recover to RUN on the next edge.

Reset
REQ-028 reset=1 at an edge: state RUN, remaining flush count 0, both counters 0.
REQ-029 While reset=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_hold=0, regardless of other inputs.
REQ-030 Reset asserted during FLUSH or FREEZE SHALL abandon that sequence; no residual flush after reset deasserts.

Structure
REQ-031 State encodings and the register-index width (5) SHALL live in the shared pipeline defines header, alongside the control-bit field positions.
REQ-032 The counters SHALL use one sub-module, sat_counter (parameter W, inputs clock/reset/inc, output count), instantiated twice.

Verification
REQ-033 ex_memRead=1, ex_rt=8, id_rs=8 -> one cycle pc_write=0, id_ex_flush=1, stall_count=1; ex_rt=0, id_rs=0 -> no stall.
REQ-034 FLUSH_CYCLES=2, branch_taken pulse -> if_id_flush=id_ex_flush=1 for exactly 2 cycles, flush_count=1; a coincident ld_use is ignored.
REQ-035 mem_busy=1 for 3 cycles in the middle of FLUSH (FLUSH_CYCLES=3) -> hold 3 cycles, then the remaining flush cycles complete; stall_count=3.
REQ-036 branch_taken and ld_use in the same RUN cycle -> branch wins: pc_write=1, stall_count unchanged.
REQ-037 CNT_W=4, 20 load-use stalls -> stall_count=15 (saturates, no wrap).
REQ-038 reset during FREEZE -> the next cycle after deassertion is normal RUN, counters=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: register-index width, hazard-controller state
// encodings and the bit positions of the packed hazard control vector.
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int FLUSH_REM_W = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_FREEZE = 2'd2
    } hz_state_t;

    localparam int CTL_W           = 5;
    localparam int CTL_PC_WRITE    = 4;
    localparam int CTL_IF_ID_WRITE = 3;
    localparam int CTL_IF_ID_FLUSH = 2;
    localparam int CTL_ID_EX_FLUSH = 1;
    localparam int CTL_PIPE_HOLD   = 0;

    typedef logic [CTL_W-1:0] ctl_t;

    // Bit order: pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold
    localparam ctl_t CTL_NORMAL = 5'b11000;
    localparam ctl_t CTL_HOLD   = 5'b00001;
    localparam ctl_t CTL_FLUSH  = 5'b11110;
    localparam ctl_t CTL_STALL  = 5'b00010;
    localparam ctl_t CTL_RESET  = 5'b00110;

    function automatic logic ld_use_hazard(
        input logic                 mem_read,
        input logic [REG_IDX_W-1:0] ex_rt,
        input logic [REG_IDX_W-1:0] id_rs,
        input logic [REG_IDX_W-1:0] id_rt,
        input logic                 uses_rt
    );
        return mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: decode/execute hazard inputs and pipeline steering outputs.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_IDX_W-1:0] id_rs;
    logic [REG_IDX_W-1:0] id_rt;
    logic                 id_uses_rt;
    logic                 ex_memRead;
    logic [REG_IDX_W-1:0] ex_rt;
    logic                 branch_taken;
    logic                 mem_busy;
    logic                 pc_write;
    logic                 if_id_write;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 pipe_hold;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memRead, ex_rt, branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memRead, ex_rt, branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// memory-busy freezes, with saturating stall/flush event counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    pipe_hazard_ctrl_if.slave      bus,
    output logic [CNT_W-1:0]       stall_count,
    output logic [CNT_W-1:0]       flush_count
);

    localparam logic [FLUSH_REM_W-1:0] FLUSH_RELOAD = FLUSH_REM_W'(FLUSH_CYCLES - 1);

    hz_state_t              r_state;
    logic [FLUSH_REM_W-1:0] r_rem;

    hz_state_t              w_next;
    logic [FLUSH_REM_W-1:0] w_rem_next;
    ctl_t                   w_ctl;
    logic                   w_ld_use;
    logic                   w_do_flush;
    logic                   w_stall_inc;
    logic                   w_flush_inc;

    assign w_ld_use = ld_use_hazard(bus.ex_memRead, bus.ex_rt, bus.id_rs,
                                    bus.id_rt, bus.id_uses_rt);

    always_comb begin
        w_ctl       = CTL_NORMAL;
        w_next      = ST_RUN;
        w_rem_next  = r_rem;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        w_do_flush  = 1'b0;

        if (reset) begin
            w_ctl      = CTL_RESET;
            w_rem_next = '0;
        end else if (bus.mem_busy) begin
            // The remaining flush count rides through the freeze untouched
            w_ctl       = CTL_HOLD;
            w_next      = ST_FREEZE;
            w_stall_inc = 1'b1;
        end else begin
            case (r_state)
                ST_FLUSH, ST_FREEZE: w_do_flush = (r_rem != '0);
                ST_RUN:              w_do_flush = 1'b0;
                default:             w_rem_next = '0;
            endcase

            if (w_do_flush) begin
                w_ctl      = CTL_FLUSH;
                w_rem_next = r_rem - 1'b1;
                w_next     = (r_rem == FLUSH_REM_W'(1)) ? ST_RUN : ST_FLUSH;
            end else if (r_state inside {ST_RUN, ST_FLUSH, ST_FREEZE}) begin
                if (bus.branch_taken) begin
                    w_ctl       = CTL_FLUSH;
                    w_flush_inc = 1'b1;
                    w_rem_next  = FLUSH_RELOAD;
                    w_next      = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                end else if (w_ld_use) begin
                    // Staying in RUN lets the next cycle re-check the same hazard
                    w_ctl       = CTL_STALL;
                    w_stall_inc = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_rem   <= '0;
        end else begin
            r_state <= w_next;
            r_rem   <= w_rem_next;
        end
    end

    assign bus.pc_write    = w_ctl[CTL_PC_WRITE];
    assign bus.if_id_write = w_ctl[CTL_IF_ID_WRITE];
    assign bus.if_id_flush = w_ctl[CTL_IF_ID_FLUSH];
    assign bus.id_ex_flush = w_ctl[CTL_ID_EX_FLUSH];
    assign bus.pipe_hold   = w_ctl[CTL_PIPE_HOLD];

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations share one stimulus stream and
// are compared each cycle against a flush-budget reference model.
module tb_pipe_hazard_ctrl;

    localparam int N = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memRead, branch_taken, mem_busy;

    pipe_hazard_ctrl_if bus_a ();
    pipe_hazard_ctrl_if bus_b ();
    pipe_hazard_ctrl_if bus_c ();

    assign bus_a.id_rs = id_rs;  assign bus_a.id_rt = id_rt;  assign bus_a.ex_rt = ex_rt;
    assign bus_a.id_uses_rt = id_uses_rt;  assign bus_a.ex_memRead = ex_memRead;
    assign bus_a.branch_taken = branch_taken;  assign bus_a.mem_busy = mem_busy;
    assign bus_b.id_rs = id_rs;  assign bus_b.id_rt = id_rt;  assign bus_b.ex_rt = ex_rt;
    assign bus_b.id_uses_rt = id_uses_rt;  assign bus_b.ex_memRead = ex_memRead;
    assign bus_b.branch_taken = branch_taken;  assign bus_b.mem_busy = mem_busy;
    assign bus_c.id_rs = id_rs;  assign bus_c.id_rt = id_rt;  assign bus_c.ex_rt = ex_rt;
    assign bus_c.id_uses_rt = id_uses_rt;  assign bus_c.ex_memRead = ex_memRead;
    assign bus_c.branch_taken = branch_taken;  assign bus_c.mem_busy = mem_busy;

    logic [15:0] sc_a, fc_a, sc_b, fc_b;
    logic [3:0]  sc_c, fc_c;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut_a (
        .clock(clock), .reset(reset), .bus(bus_a), .stall_count(sc_a), .flush_count(fc_a));
    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u_dut_b (
        .clock(clock), .reset(reset), .bus(bus_b), .stall_count(sc_b), .flush_count(fc_b));
    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u_dut_c (
        .clock(clock), .reset(reset), .bus(bus_c), .stall_count(sc_c), .flush_count(fc_c));

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
    logic [4:0]  ctl [N];
    logic [15:0] sc  [N];
    logic [15:0] fcn [N];

    assign ctl[0] = {bus_a.pc_write, bus_a.if_id_write, bus_a.if_id_flush, bus_a.id_ex_flush, bus_a.pipe_hold};
    assign ctl[1] = {bus_b.pc_write, bus_b.if_id_write, bus_b.if_id_flush, bus_b.id_ex_flush, bus_b.pipe_hold};
    assign ctl[2] = {bus_c.pc_write, bus_c.if_id_write, bus_c.if_id_flush, bus_c.id_ex_flush, bus_c.pipe_hold};
    assign sc[0] = sc_a;  assign fcn[0] = fc_a;
    assign sc[1] = sc_b;  assign fcn[1] = fc_b;
    assign sc[2] = {12'd0, sc_c};  assign fcn[2] = {12'd0, fc_c};

    string names [N] = '{"A", "B", "C"};
    int    fcyc  [N] = '{2, 3, 1};
    int    cmax  [N] = '{65535, 65535, 15};

    // Reference model: flush cycles still owed, plus the two event totals
    int m_left  [N];
    int m_stall [N];
    int m_flush [N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ut, input logic mr, input logic [4:0] ert,
                        input logic br, input logic bz);
        logic       lu;
        logic [4:0] exp;
        reset = r; id_rs = rs; id_rt = rt; id_uses_rt = ut;
        ex_memRead = mr; ex_rt = ert; branch_taken = br; mem_busy = bz;
        @(negedge clock);
        lu = mr && (ert != 0) && ((ert == rs) || (ut && (ert == rt)));
        for (int k = 0; k < N; k++) begin
            if (r)                          exp = 5'b00110;
            else if (bz)                    exp = 5'b00001;
            else if (m_left[k] > 0 || br)   exp = 5'b11110;
            else if (lu)                    exp = 5'b00010;
            else                            exp = 5'b11000;
            check({names[k], ".ctl"},   int'(ctl[k]), int'(exp));
            check({names[k], ".stall"}, int'(sc[k]),  m_stall[k]);
            check({names[k], ".flush"}, int'(fcn[k]), m_flush[k]);

            if (r) begin
                m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            end else if (bz) begin
                if (m_stall[k] < cmax[k]) m_stall[k]++;
            end else if (m_left[k] > 0) begin
                m_left[k]--;
            end else if (br) begin
                m_left[k] = fcyc[k] - 1;
                if (m_flush[k] < cmax[k]) m_flush[k]++;
            end else if (lu) begin
                if (m_stall[k] < cmax[k]) m_stall[k]++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic lduse();
        step(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end

        step(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle();

        // Load-use on rs, then on rt, then the r0 exemption
        lduse();
        idle();
        step(1'b0, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        check("A.stall_after_lduse", int'(sc_a), 2);

        // Branch coinciding with load-use, then load-use during the flush tail
        step(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        lduse();
        lduse();
        idle();
        idle();

        // Memory busy for three cycles in the middle of a flush sequence
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
        repeat (4) idle();

        // Reset arriving while frozen with flush cycles still owed
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle();
        check("B.flush_after_reset", int'(fc_b), 0);
        idle();

        // Twenty back-to-back load-use stalls saturate the 4-bit counter
        repeat (20) lduse();
        idle();
        check("C.stall_saturated", int'(sc_c), 15);
        check("A.stall_twenty", int'(sc_a), 20);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 59) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
